exec_pipe_reg: RTL

//  Parametrised decode->execute pipeline register for the 16-bit CPU core. Carries control, ALU function,

---
 rtl/exec_pipe_reg_pkg.sv | 30 +++
 rtl/exec_pipe_reg_if.sv | 50 +++++
 rtl/exec_pipe_reg_slot.sv | 40 ++++
 rtl/exec_pipe_reg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/exec_pipe_reg_pkg.sv
// Shared CPU definitions: default widths, ALU encodings and the control bundle
// carried down the decode->execute pipeline.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 4;
  localparam int CPU_FUNC_W = 2;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_func_e;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
    logic forward;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Saturating increment for 16-bit event counters (sticks at all-ones).
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/exec_pipe_reg_if.sv
// Decode-side request and execute-side result bundle of the decode->execute
// pipeline register. master = decode/control side, slave = the pipeline register.
interface exec_pipe_reg_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int FUNC_W = 2
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic              reg_write_i;
  logic              mem_write_i;
  logic              mem_to_reg_i;
  logic              forward_i;
  logic [FUNC_W-1:0] alufunc_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic [ADDR_W-1:0] dest_i;
  logic [ADDR_W-1:0] rs1_chk_i;
  logic [ADDR_W-1:0] rs2_chk_i;

  logic              valid_o;
  logic              reg_write_o;
  logic              mem_write_o;
  logic              mem_to_reg_o;
  logic              forward_o;
  logic [FUNC_W-1:0] alufunc_o;
  logic [DATA_W-1:0] src1_o;
  logic [DATA_W-1:0] src2_o;
  logic [ADDR_W-1:0] dest_o;
  logic [ADDR_W-1:0] fwd_addr_o;
  logic              load_use_o;
  logic [1:0]        raw_hit_o;
  logic [2:0]        occupancy_o;
  logic [15:0]       bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, reg_write_i, mem_write_i, mem_to_reg_i, forward_i,
    output alufunc_i, src1_i, src2_i, dest_i, rs1_chk_i, rs2_chk_i,
    input  valid_o, reg_write_o, mem_write_o, mem_to_reg_o, forward_o, alufunc_o,
    input  src1_o, src2_o, dest_o, fwd_addr_o, load_use_o, raw_hit_o, occupancy_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, reg_write_i, mem_write_i, mem_to_reg_i, forward_i,
    input  alufunc_i, src1_i, src2_i, dest_i, rs1_chk_i, rs2_chk_i,
    output valid_o, reg_write_o, mem_write_o, mem_to_reg_o, forward_o, alufunc_o,
    output src1_o, src2_o, dest_o, fwd_addr_o, load_use_o, raw_hit_o, occupancy_o, bubble_cnt_o
  );
endinterface

// File: rtl/exec_pipe_reg_slot.sv
// One pipeline stage register. Clear (flush) wins over hold (stall), which
// wins over loading the upstream value.
module exec_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Select next stage contents: bubble on clear, keep on hold, else load.
  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = '0;
    end else if (hold_i) begin
      q_d = q_q;
    end else begin
      q_d = d_i;
    end
  end

  // Stage storage with asynchronous active-low reset to an empty bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/exec_pipe_reg.sv
// Decode->execute pipeline register of DEPTH stages with valid, stall, flush,
// in-flight RAW / load-use detection, occupancy and a saturating bubble counter.
module exec_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int FUNC_W   = CPU_FUNC_W,
  parameter int DEPTH    = 1,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           reset,
  exec_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [FUNC_W-1:0] alufunc;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ADDR_W-1:0] dest;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  slot_t       in_s;
  slot_t       chain_d [DEPTH];
  slot_t       stage_q [DEPTH];
  logic [1:0]  raw_hit_s;
  logic        load_use_s;
  logic [2:0]  occ_s;
  logic        rs1_zero_s;
  logic        rs2_zero_s;
  logic [15:0] bubble_cnt_q;
  logic [15:0] bubble_cnt_d;

  // Build the stage-0 input; an invalid decode slot becomes an all-zero bubble.
  always_comb begin
    in_s = '0;
    if (bus.valid_i) begin
      in_s.valid           = 1'b1;
      in_s.ctrl.reg_write  = bus.reg_write_i;
      in_s.ctrl.mem_write  = bus.mem_write_i;
      in_s.ctrl.mem_to_reg = bus.mem_to_reg_i;
      in_s.ctrl.forward    = bus.forward_i;
      in_s.alufunc         = bus.alufunc_i;
      in_s.src1            = bus.src1_i;
      in_s.src2            = bus.src2_i;
      in_s.dest            = bus.dest_i;
    end else begin
      in_s = '0;
    end
  end

  // Chain the stages: stage 0 takes the decode input, stage k takes stage k-1.
  always_comb begin
    chain_d[0] = in_s;
    for (int k = 1; k < DEPTH; k++) begin
      chain_d[k] = stage_q[k-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    exec_pipe_slot #(.W(SLOT_W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .hold_i  (bus.stall_i),
      .clear_i (bus.flush_i),
      .d_i     (chain_d[g]),
      .q_o     (stage_q[g])
    );
  end

  // Register 0 is hardwired zero, so reading it never depends on an in-flight write.
  assign rs1_zero_s = (ZERO_REG != 0) && (bus.rs1_chk_i == '0);
  assign rs2_zero_s = (ZERO_REG != 0) && (bus.rs2_chk_i == '0);

  // Compare decode sources against every writing stage; loads also raise load-use.
  always_comb begin
    raw_hit_s  = 2'b00;
    load_use_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      raw_hit_s[0] = raw_hit_s[0] | (stage_q[k].valid & stage_q[k].ctrl.reg_write &
                                     (stage_q[k].dest == bus.rs1_chk_i) & ~rs1_zero_s);
      raw_hit_s[1] = raw_hit_s[1] | (stage_q[k].valid & stage_q[k].ctrl.reg_write &
                                     (stage_q[k].dest == bus.rs2_chk_i) & ~rs2_zero_s);
      load_use_s   = load_use_s | (stage_q[k].valid & stage_q[k].ctrl.reg_write &
                                   stage_q[k].ctrl.mem_to_reg &
                                   (((stage_q[k].dest == bus.rs1_chk_i) & ~rs1_zero_s) |
                                    ((stage_q[k].dest == bus.rs2_chk_i) & ~rs2_zero_s)));
    end
  end

  // Count valid stages currently in flight.
  always_comb begin
    occ_s = 3'd0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_s = occ_s + 3'(stage_q[k].valid);
    end
  end

  // A bubble leaves the pipe on a flush edge or on a moving edge with an empty last stage.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush_i || (!bus.stall_i && !stage_q[DEPTH-1].valid)) begin
      bubble_cnt_d = sat_inc16(bubble_cnt_q);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Bubble counter storage; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_q <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.valid_o      = stage_q[DEPTH-1].valid;
  assign bus.reg_write_o  = stage_q[DEPTH-1].ctrl.reg_write;
  assign bus.mem_write_o  = stage_q[DEPTH-1].ctrl.mem_write;
  assign bus.mem_to_reg_o = stage_q[DEPTH-1].ctrl.mem_to_reg;
  assign bus.forward_o    = stage_q[DEPTH-1].ctrl.forward;
  assign bus.alufunc_o    = stage_q[DEPTH-1].alufunc;
  assign bus.src1_o       = stage_q[DEPTH-1].src1;
  assign bus.src2_o       = stage_q[DEPTH-1].src2;
  assign bus.dest_o       = stage_q[DEPTH-1].dest;
  assign bus.fwd_addr_o   = (stage_q[DEPTH-1].valid && stage_q[DEPTH-1].ctrl.reg_write) ?
                            stage_q[DEPTH-1].dest : '0;
  assign bus.raw_hit_o    = raw_hit_s;
  assign bus.load_use_o   = load_use_s;
  assign bus.occupancy_o  = occ_s;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule
